// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: the hex glyph table,
// the blank glyph, the slot phase type and a width helper for counters.
package seg7_pkg;

    // Active-high glyphs, bit order gfedcba (g is the MSB).
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Where the scan sits inside one digit slot.
    typedef enum logic {
        PHASE_BLANK,
        PHASE_ON
    } phase_e;

    // Bits needed to count 0..n-1; never less than one bit so a
    // single-digit build still has a legal index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment glyph encoder (active-high, gfedcba).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segment
);

    // Look up the glyph for the nibble.
    always_comb begin
        // NOTE: a default before the case means every path assigns segment,
        // so no latch can be inferred even if the case list is edited later.
        segment = SEG_BLANK;
        case (nibble)
            4'h0: segment = SEG_0;
            4'h1: segment = SEG_1;
            4'h2: segment = SEG_2;
            4'h3: segment = SEG_3;
            4'h4: segment = SEG_4;
            4'h5: segment = SEG_5;
            4'h6: segment = SEG_6;
            4'h7: segment = SEG_7;
            4'h8: segment = SEG_8;
            4'h9: segment = SEG_9;
            4'hA: segment = SEG_A;
            4'hB: segment = SEG_B;
            4'hC: segment = SEG_C;
            4'hD: segment = SEG_D;
            4'hE: segment = SEG_E;
            4'hF: segment = SEG_F;
            default: segment = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. A prescaler divides each digit
// slot into a blank phase and an on phase; the value is double buffered so a
// new load only becomes visible at a frame boundary. All outputs registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 25000,
    parameter int BLANK_CYCLES   = 250,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int LZ_BLANK       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_load,
    input  logic                  i_enable,
    output logic [6:0]            o_segment,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_digit,
    output logic                  o_frame
);

    localparam int IDX_W = idx_width(N_DIGITS);
    localparam int CNT_W = idx_width(SCAN_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // XOR masks that turn active-high internal values into pin levels.
    // They double as the inactive (reset) pin levels.
    localparam logic [6:0]          SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                    : {N_DIGITS{1'b0}};

    // Scan position.
    logic [CNT_W-1:0]      count;
    logic [IDX_W-1:0]      index;

    // Double buffer: staged is written by i_load, display feeds the pins.
    logic [4*N_DIGITS-1:0] staged_value;
    logic [N_DIGITS-1:0]   staged_dp;
    logic [4*N_DIGITS-1:0] display_value;
    logic [N_DIGITS-1:0]   display_dp;
    logic                  pending;

    // Decoded state feeding the output registers.
    logic                  slot_end;
    logic                  frame_wrap;
    phase_e                phase;
    logic [3:0]            sel_nibble;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [6:0]            enc_segment;
    logic [6:0]            next_segment;
    logic [N_DIGITS-1:0]   next_digit;

    // The last count of a slot ends it; the last slot of the last digit ends the frame.
    assign slot_end   = i_enable && (count == CNT_LAST);
    assign frame_wrap = slot_end && (index == IDX_LAST);

    // Classify the current count as anti-ghosting blank time or lit time.
    always_comb begin
        phase = PHASE_ON;
        if (int'(count) < BLANK_CYCLES) begin
            phase = PHASE_BLANK;
        end
    end

    // Pick the nibble and decimal point of the scanned digit, and decide
    // whether it is a leading zero (it and every higher nibble are zero).
    always_comb begin
        logic all_zero;
        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        all_zero   = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (display_value[4*k +: 4] == 4'h0);
            if (index == IDX_W'(k)) begin
                sel_nibble = display_value[4*k +: 4];
                sel_dp     = display_dp[k];
                sel_blank  = (LZ_BLANK != 0) && (k != 0) && all_zero;
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble  (sel_nibble),
        .segment (enc_segment)
    );

    // Build the next active-high digit enable and segment pattern.
    always_comb begin
        next_segment = sel_blank ? SEG_BLANK : enc_segment;
        next_digit   = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            next_digit[k] = i_enable && (phase == PHASE_ON) && (index == IDX_W'(k));
        end
    end

    // Prescaler and digit index; both freeze while the scan is disabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            count <= '0;
            index <= '0;
        end else if (i_enable) begin
            if (slot_end) begin
                count <= '0;
                index <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Capture loads into the staging buffer and promote them at frame wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: these buffers are a handful of flops, not a RAM, so they take
        // the reset and the display is defined (shows 0) straight away.
        if (i_rst) begin
            staged_value  <= '0;
            staged_dp     <= '0;
            display_value <= '0;
            display_dp    <= '0;
            pending       <= 1'b0;
        end else begin
            if (frame_wrap && pending) begin
                display_value <= staged_value;
                display_dp    <= staged_dp;
            end
            if (i_load) begin
                staged_value <= i_value;
                staged_dp    <= i_dp;
                pending      <= 1'b1;
            end else if (frame_wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Register the pins, applying the board polarity.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_digit   <= DIG_INV;
            o_segment <= SEG_INV;
            o_dp      <= DP_INV;
            o_frame   <= 1'b0;
        end else begin
            o_digit   <= next_digit ^ DIG_INV;
            o_segment <= next_segment ^ SEG_INV;
            o_dp      <= sel_dp ^ DP_INV;
            o_frame   <= frame_wrap;
        end
    end

endmodule
